// File: rtl/apb_strb_mem.sv
// apb_strb_mem: APB slave word memory with byte strobes, programmable wait states and error response
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst_n   - synchronous active-low reset
//   psel    - slave select
//   penable - access-phase indicator
//   pwrite  - 1 = write, 0 = read
//   paddr   - byte address (ADDR_WIDTH bits)
//   pwdata  - write data (DATA_WIDTH bits)
//   pstrb   - byte-lane write enables (DATA_WIDTH/8 bits)
//   prdata  - registered read data, non-zero only in a read completion cycle
//   pready  - registered transfer completion
//   pslverr - registered error response, high only in the completion cycle
module apb_strb_mem #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int LSB        = $clog2(STRB_WIDTH);
   localparam int IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Mask of the sub-word address bits; all zero when words are single bytes.
   localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'((1 << LSB) - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                  state, state_n;
   logic [3:0]              cnt, cnt_n;
   logic                    pready_n, pslverr_n;
   logic [DATA_WIDTH-1:0]   prdata_n, rd_val;
   logic [ADDR_WIDTH-1:0]   idx;
   logic                    err, we;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   assign idx    = paddr >> LSB;
   assign err    = (32'(idx) >= 32'(DEPTH)) || (|(paddr & AMASK));
   // Only an error-free read may expose memory contents; everything else returns zero.
   assign rd_val = (!pwrite && !err) ? mem[idx[IW-1:0]] : '0;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      pready_n  = pready;
      pslverr_n = pslverr;
      prdata_n  = prdata;
      we        = 1'b0;
      case (state)
         IDLE: begin
            if (psel && !penable) begin
               cnt_n = 4'(WAIT_STATES);
               // With no wait states the counter is already at zero, so
               // pready is raised on the setup edge and the first access completes.
               if (WAIT_STATES == 0) begin
                  state_n   = DONE;
                  pready_n  = 1'b1;
                  pslverr_n = err;
                  prdata_n  = rd_val;
               end else begin
                  state_n = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_n   = IDLE;
               cnt_n     = '0;
               pready_n  = 1'b0;
               pslverr_n = 1'b0;
               prdata_n  = '0;
            end else if (penable) begin
               cnt_n = (cnt != 0) ? cnt - 4'd1 : cnt;
               if (cnt <= 4'd1) begin
                  state_n   = DONE;
                  pready_n  = 1'b1;
                  pslverr_n = err;
                  prdata_n  = rd_val;
               end
            end
         end
         DONE: begin
            if (!psel || penable) begin
               we        = psel && pwrite && !err;
               state_n   = IDLE;
               cnt_n     = '0;
               pready_n  = 1'b0;
               pslverr_n = 1'b0;
               prdata_n  = '0;
            end
         end
         default: begin
            state_n   = IDLE;
            cnt_n     = '0;
            pready_n  = 1'b0;
            pslverr_n = 1'b0;
            prdata_n  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         pready  <= pready_n;
         pslverr <= pslverr_n;
         prdata  <= prdata_n;
      end
   end

   // Memory is not reset; the write is still suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (we && rst_n) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (pstrb[i]) mem[idx[IW-1:0]][8*i +: 8] <= pwdata[8*i +: 8];
         end
      end
   end
endmodule
